// File: rtl/switch_control_pkg.sv
// Shared sizes, FSM state type and index helpers for the crossbar switch and its controller.
package switch_control_pkg;

    localparam int SW_N       = 5;
    localparam int SW_M       = 5;
    localparam int SW_OWNER_W = $clog2(SW_N);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sw_state_t;

    // Next round-robin start position after index idx, wrapping at n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    // One-hot word with bit idx set (bit 0 = LSB).
    function automatic logic [31:0] oh_encode(input int idx);
        logic [31:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Index of the lowest set bit of a one-hot word; 0 when empty.
    function automatic int oh_decode(input logic [31:0] v);
        int r;
        r = 0;
        for (int k = 31; k >= 0; k--) begin
            if (v[k]) r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_control_rr_arbiter.sv
// Round-robin picker: first set candidate searching from ptr upward with wrap.
// Purely combinational; no backpressure of its own.
module switch_control_rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [0:N-1]     cand_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] win_o,
    output logic             found_o
);

    int idx;

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            if (!found_o && cand_i[idx]) begin
                found_o = 1'b1;
                win_o   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/switch_control.sv
// Per-output wormhole arbiter/sequencer for the one-hot crossbar; select/valid/grant valid one cycle after a request is seen.
// Outputs stay locked head-to-tail and hold under i_ready=0; SWITCH_CTRL_TIMEOUT_EN adds forced release after TIMEOUT stalls.
module switch_control
    import switch_control_pkg::*;
#(
    parameter int N       = SW_N,
    parameter int M       = SW_M,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:N-1][0:M-1]    i_req,
    input  logic [0:N-1]           i_tail,
    input  logic [0:M-1]           i_ready,
    output logic [0:M-1][0:N-1]    o_sel,
    output logic [0:M-1]           o_valid,
    output logic [0:N-1]           o_grant,
    output logic [0:M-1]           o_timeout
);

    localparam int IDX_W = $clog2(N);

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    sw_state_t        state_q [M];
    sw_state_t        state_d [M];
    logic [IDX_W-1:0] owner_q [M];
    logic [IDX_W-1:0] owner_d [M];
    logic [IDX_W-1:0] ptr_q   [M];
    logic [IDX_W-1:0] ptr_d   [M];
    logic [0:N-1]     cand    [M];
    logic [IDX_W-1:0] win_idx [M];
    logic [0:M-1]     win_found;

`ifdef SWITCH_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] stall_q [M];
    logic [CNT_W-1:0] stall_d [M];
`endif

    // An input already owning one LOCKED output may not win another.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                cand[i][j] = i_req[j][i];
                for (int k = 0; k < M; k++) begin
                    if (k != i && state_q[k] == ST_LOCKED && owner_q[k] == IDX_W'(j))
                        cand[i][j] = 1'b0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_arb
        switch_control_rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
            .cand_i  (cand[gi]),
            .ptr_i   (ptr_q[gi]),
            .win_o   (win_idx[gi]),
            .found_o (win_found[gi])
        );
    end

    logic [IDX_W-1:0] ow;
    logic             xfer;

    always_comb begin
        o_sel     = '0;
        o_valid   = '0;
        o_grant   = '0;
        o_timeout = '0;
        ow        = '0;
        xfer      = 1'b0;
        for (int i = 0; i < M; i++) begin
            state_d[i] = state_q[i];
            owner_d[i] = owner_q[i];
            ptr_d[i]   = ptr_q[i];
`ifdef SWITCH_CTRL_TIMEOUT_EN
            stall_d[i] = stall_q[i];
`endif
            if (state_q[i] == ST_IDLE) begin
                if (win_found[i]) begin
                    owner_d[i] = win_idx[i];
                    state_d[i] = ST_LOCKED;
`ifdef SWITCH_CTRL_TIMEOUT_EN
                    stall_d[i] = '0;
`endif
                end
            end else begin
                ow            = owner_q[i];
                o_sel[i][ow]  = 1'b1;
`ifdef SWITCH_CTRL_TIMEOUT_EN
                if (stall_q[i] == CNT_W'(TIMEOUT)) begin
                    o_timeout[i] = 1'b1;
                    state_d[i]   = ST_IDLE;
                    ptr_d[i]     = IDX_W'(rr_next(int'(ow), N));
                    stall_d[i]   = '0;
                end else begin
`else
                begin
`endif
                    o_valid[i] = i_req[ow][i];
                    xfer       = o_valid[i] & i_ready[i];
                    if (xfer) begin
                        o_grant[ow] = 1'b1;
`ifdef SWITCH_CTRL_TIMEOUT_EN
                        stall_d[i]  = '0;
`endif
                        if (i_tail[ow]) begin
                            state_d[i] = ST_IDLE;
                            ptr_d[i]   = IDX_W'(rr_next(int'(ow), N));
                        end
                    end
`ifdef SWITCH_CTRL_TIMEOUT_EN
                    else begin
                        stall_d[i] = stall_q[i] + 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < M; i++) begin
                state_q[i] <= ST_IDLE;
                owner_q[i] <= '0;
                ptr_q[i]   <= '0;
`ifdef SWITCH_CTRL_TIMEOUT_EN
                stall_q[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                state_q[i] <= state_d[i];
                owner_q[i] <= owner_d[i];
                ptr_q[i]   <= ptr_d[i];
`ifdef SWITCH_CTRL_TIMEOUT_EN
                stall_q[i] <= stall_d[i];
`endif
            end
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_req_chk
        a_req_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(i_req[gj]));
    end

endmodule

// File: doc/switch_control.md
Name: switch_control

Overview:
- Per-output wormhole arbiter and sequencer for the NxM one-hot crossbar switch_onehot_packet.
- Takes route requests from N input buffers and decides which input owns each of the M outputs.
- Holds each output locked to its owner from head flit to tail flit, honouring downstream backpressure.
- Drives the crossbar's one-hot select directly and returns per-input grants (flit consumed) to the input buffers.

Parameters:
- N, 5, number of crossbar inputs (>=2)
- M, 5, number of crossbar outputs (>=1)
- TIMEOUT, 64, stall cycles before forced release; used only with SWITCH_CTRL_TIMEOUT_EN

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- i_req  input  [0:N-1][0:M-1]  i_req[j][i]=1: input j's head-of-queue flit targets output i; each row one-hot or zero
- i_tail  input  [0:N-1]  input j's head-of-queue flit is a tail flit
- i_ready  input  [0:M-1]  downstream of output i accepts a flit this cycle
- o_sel  output  [0:M-1][0:N-1]  one-hot crossbar select; o_sel[i][j]=1 routes input j to output i; all-zero means output driven '0
- o_valid  output  [0:M-1]  output i carries a valid flit this cycle
- o_grant  output  [0:N-1]  input j's flit is transferred this cycle; input pops its queue
- o_timeout  output  [0:M-1]  one-cycle pulse when output i is forcibly released

Behaviour:
- Per-output FSM, states IDLE and LOCKED. Per-output state:
  - owner register, width $clog2(N)
  - round-robin pointer ptr, width $clog2(N)
- Reset (synchronous, dominates all other events, including mid-packet):
  - all FSMs go to IDLE; owners=0; ptr=0; stall counters=0
  - o_sel='0, o_valid='0, o_grant='0, o_timeout='0 in the cycle after reset is sampled high
- IDLE, output i:
  - candidates = { j : i_req[j][i]=1 and input j is not owner of another LOCKED output }
  - if any candidate: winner = first candidate searching j=ptr, ptr+1, ..., wrapping N-1 -> 0; owner<=winner; go to LOCKED
  - o_sel[i]='0, o_valid[i]=0
- LOCKED, output i:
  - o_sel[i]=one-hot(owner), with bit 0 leftmost
  - o_valid[i]=i_req[owner][i]
  - transfer = o_valid[i] & i_ready[i]; o_grant[owner] asserted in that same cycle
  - transfer with i_tail[owner]=1: go to IDLE; ptr<=(owner==N-1)?0:owner+1
  - owner deasserts its request mid-packet: stays LOCKED (wormhole hold); no transfer
  - i_ready[i]=0: select held, no grant, no owner change
- Latency:
  - request sampled in cycle t, select and first possible transfer in t+1
  - single-flit packets sustain 1 packet per 2 cycles per output
  - multi-flit packets sustain 1 flit/cycle after lock
- Output signal composition:
  - o_grant[j] = OR over outputs of (transfer & owner==j); at most one term is true given one-hot requests
  - o_sel, o_valid and o_grant are combinational from registered state plus i_req, i_tail and i_ready; no combinational path from i_req into o_sel
- Independent outputs arbitrate in parallel; different outputs may lock in the same cycle.
- Multi-hot i_req row is illegal and flagged by a simulation assertion; the RTL is not required to handle it.

Optional Feature:
- Macro: SWITCH_CTRL_TIMEOUT_EN
- Defined:
  - per-output stall counter, width $clog2(TIMEOUT+1)
  - counts LOCKED cycles without a transfer; cleared on transfer or on entering LOCKED
  - when counter reaches TIMEOUT: go to IDLE, ptr<=owner+1 (wrapping), pulse o_timeout[i] for one cycle; no grant that cycle
- Undefined: no counters; a LOCKED output is released only by a tail transfer or reset; o_timeout tied to '0.

Decomposition:
- packet_t and global sizes remain in config.sv.
- Add a shared package constant for the owner index width, and a one-hot encode/decode function pair reused by the switch and this controller.
- One natural sub-module: switch_control_rr_arbiter.
  - Interface: N-bit candidate vector plus ptr in; winner index and found flag out.
  - Combinational; instantiated M times.

Test Plan (N=5, M=5, all i_ready=1 unless stated):
- Reset: assert reset 2 cycles with requests active -> o_sel, o_valid, o_grant all 0; first lock occurs one cycle after reset release.
- Single packet: i_req[2]=00010 (output 3), 3-flit packet with tail on the 3rd flit -> o_sel[3]=00100 from cycle 1; o_grant[2]=1 in cycles 1-3; output 3 IDLE in cycle 4; ptr[3]=3.
- Contention: inputs 0, 1, 4 request output 0 with continuous single-flit packets, ptr=0 -> grants in order 0, 1, 4, 0, each 2 cycles apart.
- Backpressure and parallelism:
  - input 1 to output 2 and input 3 to output 4 issued together -> both locked in the same cycle.
  - i_ready[2]=0 for 4 cycles mid-packet -> o_sel[2] held at 01000, o_grant[1]=0 during the stall; packet completes afterwards with no flit loss.
- Wrap: ptr=4, inputs 4 and 0 request output 1 -> 4 wins, then 0; ptr returns to 1.
- Timeout (SWITCH_CTRL_TIMEOUT_EN, TIMEOUT=8): input 0 sends head flit then drops its request -> o_timeout[i] pulses after 8 stall cycles, output goes IDLE, waiting input 2 locks in the next cycle. Without the macro, output stays LOCKED indefinitely.
